// File: rtl/sev_seg_mux.sv
// ---------------------------------------------------------------------------
// sev_seg_mux
// Multiplexed seven-segment display driver with a sequential binary-to-BCD
// converter, a programmable refresh prescaler, leading-zero blanking,
// per-digit decimal points and 16-level brightness PWM.
//
// Handshake (valid/ready): strobe is the request and busy low is the ready.
// A capture happens on any rising clk edge where strobe=1 and busy=0. While
// busy=1 strobe is ignored and nothing is queued. busy falls on the same edge
// that loads the finished result into the display registers.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-low reset
//   num       unsigned binary value to display
//   strobe    capture request for num
//   blank_lz  1 = blank leading zeros (digit 0 is never blanked)
//   dp        decimal point enables, bit i = digit i
//   bright    on-subphases per digit slot (0 = dark, 15 = 15/16 duty)
//   busy      conversion in progress; it is also the converter FSM state
//   LEDs      segments {G,F,E,D,C,B,A}
//   dp_o      decimal point of the digit being driven
//   sel       binary index of the digit being driven
//   en        digit enable (brightness PWM)
// ---------------------------------------------------------------------------
module sev_seg_mux #(
  parameter int DIGITS         = 4,
  parameter int NUM_W          = 16,
  parameter int PRESCALE       = 64,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_W-1:0]          num,
  input  logic                      strobe,
  input  logic                      blank_lz,
  input  logic [DIGITS-1:0]         dp,
  input  logic [3:0]                bright,
  output logic                      busy,
  output logic [6:0]                LEDs,
  output logic                      dp_o,
  output logic [$clog2(DIGITS)-1:0] sel,
  output logic                      en
);

  localparam int SEL_W = $clog2(DIGITS);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest value that fits in DIGITS decimal digits.
  localparam logic [63:0]      MAX_VAL   = pow10(DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [6:0]       SEG_ZERO  = 7'b1000000;  // active-low "0"
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;  // active-low all off
  localparam logic             POL_LOW   = (ACTIVE_LOW_SEG != 0);
  localparam logic [6:0]       LEDS_RST  = POL_LOW ? SEG_ZERO : ~SEG_ZERO;
  localparam logic             DP_OFF    = POL_LOW ? 1'b1 : 1'b0;

  // Active-low GFE_DCBA decode.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Converter FSM
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;
  logic [BCD_W-1:0]   disp_q;
  logic               load, step, done;
  logic [BCD_W-1:0]   bcd_adj, bcd_next;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          load    = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(NUM_W - 1)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Double dabble: add 3 to every BCD nibble >= 5, then shift in the next
  // binary MSB. The nibble overflowing out of the top only happens for
  // saturated inputs, whose result is replaced by all nines anyway.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = BCD_W'({bcd_adj, bin_q[NUM_W-1]});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        bin_q <= num;
        bcd_q <= '0;
        cnt_q <= '0;
        sat_q <= (64'(num) > MAX_VAL);
      end else if (step) begin
        bin_q <= bin_q << 1;
        bcd_q <= bcd_next;
        cnt_q <= cnt_q + CNT_W'(1);
        // Display registers only ever see a finished result.
        if (done) disp_q <= sat_q ? ALL_NINES : bcd_next;
      end
    end
  end

  assign busy = (state_q == ST_CONV);

  // -------------------------------------------------------------------------
  // Refresh: prescaler -> 16 brightness subphases -> digit index
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_q;
  logic [3:0]       sub_q;
  logic [SEL_W-1:0] idx_q;
  logic             pre_wrap, sub_wrap;

  assign pre_wrap = (pre_q == PRE_W'(PRESCALE - 1));
  assign sub_wrap = pre_wrap && (sub_q == 4'hF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_wrap ? '0 : pre_q + PRE_W'(1);
      if (pre_wrap) sub_q <= sub_q + 4'd1;
      if (sub_wrap) idx_q <= (idx_q == SEL_W'(DIGITS - 1)) ? '0 : idx_q + SEL_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Blanking and digit selection
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0] blank_vec;
  logic              upper_zero;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic              cur_dp;
  logic [6:0]        seg_al;

  // Digit i is blanked when it and every more significant digit are zero.
  always_comb begin
    blank_vec  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (disp_q[4*i +: 4] == 4'd0);
      blank_vec[i] = blank_lz && upper_zero;
    end
  end

  always_comb begin
    cur_digit = disp_q[3:0];
    cur_blank = 1'b0;
    cur_dp    = dp[0];
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == SEL_W'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        cur_blank = blank_vec[i];
        cur_dp    = dp[i];
      end
    end
    seg_al = cur_blank ? SEG_BLANK : decode(cur_digit);
  end

  // -------------------------------------------------------------------------
  // Registered outputs, one cycle behind the refresh counters
  // -------------------------------------------------------------------------
  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic [6:0]       leds_q;
  logic             dpo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q  <= '0;
      en_q   <= 1'b0;
      leds_q <= LEDS_RST;
      dpo_q  <= DP_OFF;
    end else begin
      sel_q  <= idx_q;
      en_q   <= (sub_q < bright);
      leds_q <= POL_LOW ? seg_al : ~seg_al;
      dpo_q  <= POL_LOW ? ~cur_dp : cur_dp;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign LEDs = leds_q;
  assign dp_o = dpo_q;

endmodule

// File: tb/tb_sev_seg_mux.sv
// ---------------------------------------------------------------------------
// tb_sev_seg_mux
// Two instances share all inputs: dut_a is active-low, dut_b active-high.
// The reference model derives the expected display from plain arithmetic:
// decimal digits by division, scan position and PWM subphase from the number
// of clocks elapsed since reset.
// ---------------------------------------------------------------------------
module tb_sev_seg_mux;
  localparam int D    = 4;
  localparam int NW   = 16;
  localparam int P    = 4;
  localparam int SLOT = 16 * P;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NW-1:0] num      = '0;
  logic          strobe   = 1'b0;
  logic          blank_lz = 1'b0;
  logic [D-1:0]  dp       = '0;
  logic [3:0]    bright   = '0;

  logic       busy_a, busy_b, dpo_a, dpo_b, en_a, en_b;
  logic [6:0] leds_a, leds_b;
  logic [1:0] sel_a, sel_b;

  sev_seg_mux #(.DIGITS(D), .NUM_W(NW), .PRESCALE(P), .ACTIVE_LOW_SEG(1)) dut_a (
    .clk(clk), .reset(reset), .num(num), .strobe(strobe), .blank_lz(blank_lz),
    .dp(dp), .bright(bright), .busy(busy_a), .LEDs(leds_a), .dp_o(dpo_a),
    .sel(sel_a), .en(en_a)
  );

  sev_seg_mux #(.DIGITS(D), .NUM_W(NW), .PRESCALE(P), .ACTIVE_LOW_SEG(0)) dut_b (
    .clk(clk), .reset(reset), .num(num), .strobe(strobe), .blank_lz(blank_lz),
    .dp(dp), .bright(bright), .busy(busy_b), .LEDs(leds_b), .dp_o(dpo_b),
    .sel(sel_b), .en(en_b)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected digits and strobe edge per accepted capture
  logic [4*D-1:0] exp_q[$];
  int             st_q[$];

  // Rising edges since reset release; inputs as sampled by the last edge
  int         edge_cnt;
  logic [3:0] bright_s;
  logic [D-1:0] dp_s;
  logic       blz_s;

  always @(posedge clk or negedge reset) begin
    if (!reset) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(posedge clk) begin
    bright_s <= bright;
    dp_s     <= dp;
    blz_s    <= blank_lz;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;  4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;  4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;  4'd8: s = 7'b0000000;
      4'd9: s = 7'b0011000;  default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  function automatic logic [4*D-1:0] ref_digits(input logic [NW-1:0] n);
    longint v, maxv;
    logic [4*D-1:0] r;
    maxv = 1;
    for (int i = 0; i < D; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    v = longint'(n);
    if (v > maxv) v = maxv;
    r = '0;
    for (int j = 0; j < D; j++) begin
      r[4*j +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Monitor: compares every output each cycle, pops the scoreboard on busy fall
  logic [4*D-1:0] cur_disp  = '0;
  logic           busy_prev = 1'b0;
  int             k, slot, sub, s_edge;
  logic [3:0]     dg;
  logic           blanked, exp_dpa, exp_dpb;
  logic [6:0]     exp_al, exp_ah;
  logic [4*D-1:0] popped;

  always @(negedge clk) begin
    if (!reset || edge_cnt == 0) begin
      check("rst_busy", busy_a, 0);
      check("rst_sel", sel_a, 0);
      check("rst_en", en_a, 0);
      check("rst_leds_lo", leds_a, 7'b1000000);
      check("rst_dp_lo", dpo_a, 1);
      check("rst_leds_hi", leds_b, 7'b0111111);
      check("rst_dp_hi", dpo_b, 0);
      cur_disp  = '0;
      busy_prev = 1'b0;
      exp_q.delete();
      st_q.delete();
    end else begin
      k       = edge_cnt - 1;
      slot    = (k / SLOT) % D;
      sub     = (k / P) % 16;
      dg      = cur_disp[4*slot +: 4];
      blanked = blz_s && (slot > 0) && ((cur_disp >> (4 * slot)) == '0);
      exp_al  = blanked ? 7'b1111111 : seg_of(dg);
      exp_ah  = ~exp_al;
      exp_dpa = ~dp_s[slot];
      exp_dpb = dp_s[slot];
      check("sel", sel_a, slot);
      check("sel_hi", sel_b, slot);
      check("en", en_a, (sub < int'(bright_s)));
      check("leds_lo", leds_a, exp_al);
      check("leds_hi", leds_b, exp_ah);
      check("dp_lo", dpo_a, exp_dpa);
      check("dp_hi", dpo_b, exp_dpb);

      if (busy_a && !busy_prev) begin
        if (st_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL busy_rise: got unexpected capture, expected none (edge %0d)", edge_cnt);
        end else begin
          check("busy_rise_edge", edge_cnt, st_q[0]);
        end
      end
      if (!busy_a && busy_prev) begin
        if (exp_q.size() == 0 || st_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL busy_fall: got unexpected completion, expected none (edge %0d)", edge_cnt);
        end else begin
          s_edge = st_q.pop_front();
          popped = exp_q.pop_front();
          check("latency", edge_cnt - s_edge + 1, NW + 1);
          cur_disp = popped;
        end
      end
      busy_prev = busy_a;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_a !== 1'b0 && t < 200) begin
      tick(1);
      t++;
    end
    if (busy_a !== 1'b0) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=%b after 200 cycles, expected 0", busy_a);
    end
  endtask

  task automatic convert(input logic [NW-1:0] n);
    wait_idle();
    num    = n;
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
    st_q.push_back(edge_cnt);
    exp_q.push_back(ref_digits(n));
    num = NW'($urandom);
  endtask

  // Strobe while a conversion is running; must be ignored.
  task automatic poke(input logic [NW-1:0] n);
    num    = n;
    strobe = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] n;
    tick(3);
    reset = 1'b1;
    tick(2);
    bright = 4'd15;

    convert(16'd1234);
    tick(4 * SLOT + 30);

    convert(16'd12345);  // saturates to 9999
    tick(5);
    poke(16'd7);
    tick(4 * SLOT + 30);

    blank_lz = 1'b1;
    convert(16'd42);
    tick(4 * SLOT + 30);
    blank_lz = 1'b0;
    tick(4 * SLOT + 4);
    blank_lz = 1'b1;
    convert(16'd0);
    tick(4 * SLOT + 30);

    convert(16'd8888);
    bright = 4'd5;
    dp     = 4'b0100;
    tick(4 * SLOT + 30);
    bright = 4'd0;
    tick(4 * SLOT + 4);

    bright = 4'd9;
    convert(16'd9876);
    convert(16'd5);      // back-to-back
    tick(4 * SLOT + 30);

    for (int i = 0; i < 15; i++) begin
      bright   = 4'($urandom_range(0, 15));
      dp       = D'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       n = NW'($urandom_range(0, 9999));
        1:       n = NW'($urandom_range(0, 99));
        default: n = NW'($urandom);
      endcase
      convert(n);
      if ($urandom_range(0, 3) == 0) begin
        tick(3);
        poke(NW'($urandom));
      end
      tick($urandom_range(20, 300));
      if ($urandom_range(0, 1) == 1) bright = 4'($urandom_range(0, 15));
      tick($urandom_range(1, 60));
    end
    wait_idle();
    tick(20);

    // Reset in the middle of a conversion
    blank_lz = 1'b0;
    convert(16'd5678);
    tick(8);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(4 * SLOT + 10);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
